// File: rtl/mcn_req_buffer_pkg.sv
// Shared definitions for the MAU-to-MCN request buffer: FSM state encodings
// and read/write direction constants.
package mcn_req_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/mcn_req_buffer_req_fifo.sv
// Request queue for mcn_req_buffer: circular storage with wrap-around
// pointers, occupancy count and full/empty flags.
module req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 42
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    // Guards keep the count inside 0..DEPTH even if a caller misbehaves.
    assign push_ok = push_i && (count_q != CNT_FULL);
    assign pop_ok  = pop_i && (count_q != '0);

    always_comb begin
        wptr_d  = push_ok ? wptr_q + PTR_ONE : wptr_q;
        rptr_d  = pop_ok  ? rptr_q + PTR_ONE : rptr_q;
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/mcn_req_buffer.sv
// Buffers MAU requests and issues them to the MCN one at a time, in order,
// returning read data to the MAU.
module mcn_req_buffer
    import mcn_req_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 9,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   reqMAU,
    input  logic                   rwMAU,
    input  logic [AW-1:0]          addrMAU,
    input  logic [DW-1:0]          dinMAU,
    output logic                   ackMAU,
    output logic [DW-1:0]          rdataMAU,
    output logic                   rvalidMAU,
    output logic                   reqMCN,
    output logic                   rwMCN,
    output logic [AW-1:0]          addrMCN,
    output logic [DW-1:0]          doutMCN,
    input  logic                   ackMCN,
    input  logic [DW-1:0]          rdataMCN,
    input  logic                   halt,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int EW = 1 + AW + DW;

    state_e          state_q, state_d;
    logic            ack_q;
    logic            req_q, req_d;
    logic            rw_q, rw_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic            rvalid_q, rvalid_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [EW-1:0]   head;
    logic            cap, pop;

    // The ack cycle blocks capture so a still-held reqMAU is not taken twice.
    assign cap = reqMAU && !full && !ack_q;

    req_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (cap),
        .pop_i   (pop),
        .wdata_i ({rwMAU, addrMAU, dinMAU}),
        .rdata_o (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        dout_d   = dout_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !halt) begin
                    state_d                = ISSUE;
                    req_d                  = 1'b1;
                    {rw_d, addr_d, dout_d} = head;
                end
            end
            ISSUE: begin
                if (ackMCN) begin
                    pop     = 1'b1;
                    state_d = RESP;
                    req_d   = 1'b0;
                    if (rw_q == RW_READ) begin
                        rvalid_d = 1'b1;
                        rdata_d  = rdataMCN;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            req_q    <= 1'b0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            dout_q   <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= cap;
            req_q    <= req_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign ackMAU    = ack_q;
    assign reqMCN    = req_q;
    assign rwMCN     = rw_q;
    assign addrMCN   = addr_q;
    assign doutMCN   = dout_q;
    assign rvalidMAU = rvalid_q;
    assign rdataMAU  = rdata_q;

endmodule

// File: tb/tb_mcn_req_buffer.sv
// Directed self-checking bench for mcn_req_buffer.
module tb_mcn_req_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqMAU, rwMAU;
    logic [8:0]  addrMAU;
    logic [31:0] dinMAU;
    logic        ackMAU, rvalidMAU;
    logic [31:0] rdataMAU;
    logic        reqMCN, rwMCN;
    logic [8:0]  addrMCN;
    logic [31:0] doutMCN;
    logic        ackMCN;
    logic [31:0] rdataMCN;
    logic        halt;
    logic [2:0]  count;
    logic        full, empty;

    int checks = 0;
    int errors = 0;

    mcn_req_buffer #(.DEPTH(4), .AW(9), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .reqMAU(reqMAU), .rwMAU(rwMAU), .addrMAU(addrMAU), .dinMAU(dinMAU),
        .ackMAU(ackMAU), .rdataMAU(rdataMAU), .rvalidMAU(rvalidMAU),
        .reqMCN(reqMCN), .rwMCN(rwMCN), .addrMCN(addrMCN), .doutMCN(doutMCN),
        .ackMCN(ackMCN), .rdataMCN(rdataMCN), .halt(halt),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one MAU request and holds it until ackMAU is seen (bounded).
    task automatic push(input logic rw, input logic [8:0] a, input logic [31:0] d,
                        output bit ok);
        reqMAU = 1'b1; rwMAU = rw; addrMAU = a; dinMAU = d;
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ackMAU) begin ok = 1'b1; break; end
        end
        reqMAU = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = reqMCN;
        for (int i = 0; i < 12 && !ok; i++) begin
            tick();
            ok = reqMCN;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; reqMAU = 0; rwMAU = 0; addrMAU = '0; dinMAU = '0;
        ackMCN = 0; rdataMCN = '0; halt = 0;
        #1;
        checks++;
        if ({ackMAU, rvalidMAU, reqMCN, rwMCN, addrMCN, doutMCN, rdataMAU} !== '0) begin
            errors++; $display("FAIL reset_outputs got %h required 0",
                {ackMAU, rvalidMAU, reqMCN, rwMCN, addrMCN, doutMCN, rdataMAU});
        end
        checks++;
        if ({count, empty, full} !== 5'b000_1_0) begin
            errors++; $display("FAIL reset_flags got %b required 00010", {count, empty, full});
        end
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_write();
        bit ok;
        reqMAU = 1; rwMAU = 1; addrMAU = 9'h015; dinMAU = 32'hDEADBEEF;
        tick();
        checks++;
        if (ackMAU !== 1'b1 || count !== 3'd1) begin
            errors++; $display("FAIL wr_ack_n1 got ack=%b count=%0d required ack=1 count=1", ackMAU, count);
        end
        tick();  // reqMAU still held during the ack cycle
        reqMAU = 0;
        checks++;
        if (ackMAU !== 1'b0 || count !== 3'd1) begin
            errors++; $display("FAIL wr_no_double got ack=%b count=%0d required ack=0 count=1", ackMAU, count);
        end
        checks++;
        if ({reqMCN, rwMCN, addrMCN, doutMCN} !== {1'b1, 1'b1, 9'h015, 32'hDEADBEEF}) begin
            errors++; $display("FAIL wr_req_n2 got %b %b %h %h required 1 1 015 deadbeef",
                reqMCN, rwMCN, addrMCN, doutMCN);
        end
        tick(); tick();
        ackMCN = 1;
        checks++;
        if (reqMCN !== 1'b1) begin
            errors++; $display("FAIL wr_req_hold got %b required 1", reqMCN);
        end
        tick();
        ackMCN = 0;
        checks++;
        if ({reqMCN, rvalidMAU, count} !== {1'b0, 1'b0, 3'd0}) begin
            errors++; $display("FAIL wr_done got req=%b rvalid=%b count=%0d required 0 0 0",
                reqMCN, rvalidMAU, count);
        end
        tick();
        checks++;
        if (rvalidMAU !== 1'b0 || empty !== 1'b1) begin
            errors++; $display("FAIL wr_no_rvalid got rvalid=%b empty=%b required 0 1", rvalidMAU, empty);
        end
        ok = 1'b1;
    endtask

    task automatic test_read();
        bit ok;
        push(1'b0, 9'h040, 32'h0, ok);
        wait_req(ok);
        checks++;
        if (!ok || rwMCN !== 1'b0 || addrMCN !== 9'h040) begin
            errors++; $display("FAIL rd_issue got ok=%b rw=%b addr=%h required 1 0 040", ok, rwMCN, addrMCN);
        end
        ackMCN = 1; rdataMCN = 32'h12345678;
        tick();
        ackMCN = 0; rdataMCN = 32'hFFFFFFFF;
        checks++;
        if (rvalidMAU !== 1'b1 || rdataMAU !== 32'h12345678) begin
            errors++; $display("FAIL rd_return got rvalid=%b data=%h required 1 12345678", rvalidMAU, rdataMAU);
        end
        tick();
        checks++;
        if (rvalidMAU !== 1'b0 || rdataMAU !== 32'h12345678) begin
            errors++; $display("FAIL rd_hold got rvalid=%b data=%h required 0 12345678", rvalidMAU, rdataMAU);
        end
        // A stray ackMCN outside ISSUE must not produce a completion.
        ackMCN = 1;
        tick();
        ackMCN = 0;
        tick();
        checks++;
        if (rvalidMAU !== 1'b0 || count !== 3'd0) begin
            errors++; $display("FAIL rd_stray_ack got rvalid=%b count=%0d required 0 0", rvalidMAU, count);
        end
    endtask

    task automatic test_full();
        bit ok;
        int acks = 0;
        for (int i = 0; i < 4; i++) begin
            push(1'b1, 9'h100 + 9'(i), 32'hA000_0000 + i, ok);
            if (ok) acks++;
        end
        checks++;
        if (acks != 4 || full !== 1'b1 || count !== 3'd4) begin
            errors++; $display("FAIL full_fill got acks=%0d full=%b count=%0d required 4 1 4", acks, full, count);
        end
        reqMAU = 1; rwMAU = 1; addrMAU = 9'h104; dinMAU = 32'hA000_0004;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ackMAU) acks++;
        end
        checks++;
        if (acks != 0 || count !== 3'd4 || reqMCN !== 1'b1 || addrMCN !== 9'h100) begin
            errors++; $display("FAIL full_wait got acks=%0d count=%0d req=%b addr=%h required 0 4 1 100",
                acks, count, reqMCN, addrMCN);
        end
        ackMCN = 1;
        tick();
        ackMCN = 0;
        checks++;
        if (count !== 3'd3 || ackMAU !== 1'b0) begin
            errors++; $display("FAIL full_pop got count=%0d ack=%b required 3 0", count, ackMAU);
        end
        tick();
        reqMAU = 0;
        checks++;
        if (ackMAU !== 1'b1 || count !== 3'd4 || full !== 1'b1) begin
            errors++; $display("FAIL full_fifth got ack=%b count=%0d full=%b required 1 4 1", ackMAU, count, full);
        end
        for (int i = 1; i <= 4; i++) begin
            wait_req(ok);
            checks++;
            if (!ok || addrMCN !== 9'h100 + 9'(i) || doutMCN !== 32'hA000_0000 + i) begin
                errors++; $display("FAIL full_order%0d got ok=%b addr=%h data=%h required 1 %h %h",
                    i, ok, addrMCN, doutMCN, 9'h100 + 9'(i), 32'hA000_0000 + i);
            end
            ackMCN = 1;
            tick();
            ackMCN = 0;
        end
        tick();
        checks++;
        if (empty !== 1'b1 || reqMCN !== 1'b0) begin
            errors++; $display("FAIL full_drain got empty=%b req=%b required 1 0", empty, reqMCN);
        end
    endtask

    task automatic test_halt();
        bit ok;
        halt = 1;
        push(1'b1, 9'h0A1, 32'h11, ok);
        push(1'b1, 9'h0A2, 32'h22, ok);
        repeat (4) tick();
        checks++;
        if (reqMCN !== 1'b0 || count !== 3'd2) begin
            errors++; $display("FAIL halt_block got req=%b count=%0d required 0 2", reqMCN, count);
        end
        halt = 0;
        tick();
        checks++;
        if (reqMCN !== 1'b1 || addrMCN !== 9'h0A1) begin
            errors++; $display("FAIL halt_first got req=%b addr=%h required 1 0a1", reqMCN, addrMCN);
        end
        halt = 1;
        tick(); tick();
        checks++;
        if (reqMCN !== 1'b1 || addrMCN !== 9'h0A1) begin
            errors++; $display("FAIL halt_in_issue got req=%b addr=%h required 1 0a1", reqMCN, addrMCN);
        end
        halt = 0;
        ackMCN = 1;
        tick();
        ackMCN = 0;
        wait_req(ok);
        checks++;
        if (!ok || addrMCN !== 9'h0A2) begin
            errors++; $display("FAIL halt_second got ok=%b addr=%h required 1 0a2", ok, addrMCN);
        end
        ackMCN = 1;
        tick();
        ackMCN = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        bit ok;
        halt = 1;
        push(1'b1, 9'h0B1, 32'hB1, ok);
        push(1'b1, 9'h0B2, 32'hB2, ok);
        halt = 0;
        wait_req(ok);
        checks++;
        if (!ok || count !== 3'd2 || addrMCN !== 9'h0B1) begin
            errors++; $display("FAIL b2b_setup got ok=%b count=%0d addr=%h required 1 2 0b1", ok, count, addrMCN);
        end
        reqMAU = 1; rwMAU = 1; addrMAU = 9'h0B3; dinMAU = 32'hB3;
        ackMCN = 1;
        tick();
        reqMAU = 0; ackMCN = 0;
        checks++;
        if (count !== 3'd2 || ackMAU !== 1'b1 || reqMCN !== 1'b0) begin
            errors++; $display("FAIL b2b_same_cycle got count=%0d ack=%b req=%b required 2 1 0",
                count, ackMAU, reqMCN);
        end
        push(1'b1, 9'h0B4, 32'hB4, ok);
        checks++;
        if (!ok || count !== 3'd3) begin
            errors++; $display("FAIL b2b_push got ok=%b count=%0d required 1 3", ok, count);
        end
        for (int i = 2; i <= 4; i++) begin
            wait_req(ok);
            checks++;
            if (!ok || addrMCN !== 9'h0B0 + 9'(i) || doutMCN !== 32'hB0 + i) begin
                errors++; $display("FAIL b2b_order%0d got ok=%b addr=%h data=%h required 1 %h %h",
                    i, ok, addrMCN, doutMCN, 9'h0B0 + 9'(i), 32'hB0 + i);
            end
            ackMCN = 1;
            tick();
            ackMCN = 0;
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int bad = 0;
        halt = 1;
        push(1'b0, 9'h0C1, 32'h0, ok);
        push(1'b0, 9'h0C2, 32'h0, ok);
        push(1'b0, 9'h0C3, 32'h0, ok);
        halt = 0;
        wait_req(ok);
        checks++;
        if (!ok || count !== 3'd3) begin
            errors++; $display("FAIL rst_mid_setup got ok=%b count=%0d required 1 3", ok, count);
        end
        @(negedge clk);
        reset = 0;
        #1;
        checks++;
        if (reqMCN !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
            errors++; $display("FAIL rst_mid_async got req=%b count=%0d empty=%b required 0 0 1",
                reqMCN, count, empty);
        end
        ackMCN = 1; rdataMCN = 32'hBAD0BAD0;
        tick(); tick();
        ackMCN = 0;
        @(negedge clk);
        reset = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rvalidMAU !== 1'b0 || reqMCN !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || rdataMAU !== 32'h0) begin
            errors++; $display("FAIL rst_mid_after got bad_cycles=%0d rdata=%h required 0 0", bad, rdataMAU);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_full();
        test_halt();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
